// File: rtl/ex_muldiv_seq_if.sv
// EX-stage <-> mul/div sequencer bus: op request, operands, HI/LO readback and stall feedback.
// master = EX stage side, slave = sequencer side.
interface ex_muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             OpValid;
   logic [2:0]       Op;
   logic             Stall;
   logic             Flush;
   logic [WIDTH-1:0] ReadData1;
   logic [WIDTH-1:0] ReadData2;
   logic [WIDTH-1:0] Result;
   logic             ALUStall;
   logic             Busy;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output OpValid, Op, Stall, Flush, ReadData1, ReadData2,
      input  Result, ALUStall, Busy, Hi, Lo
   );

   modport slave (
      input  OpValid, Op, Stall, Flush, ReadData1, ReadData2,
      output Result, ALUStall, Busy, Hi, Lo
   );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Radix-2 MULT/MULTU/DIV/DIVU sequencer owning HI/LO; Busy for WIDTH+1 cycles after accept (RUN x WIDTH, FIX x 1).
// Nothing is accepted while Busy; any op presented meanwhile raises ALUStall unless flushed.
module ex_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   ex_muldiv_seq_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state;
   logic [CW-1:0]      counter;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic [WIDTH-1:0]   opA;      // multiplicand / dividend magnitude (shifted left for divide)
   logic [WIDTH-1:0]   opB;      // multiplier (shifted right) / divisor magnitude
   logic [WIDTH-1:0]   rawA;
   logic               sa;
   logic               sb;
   logic               isDiv;
   logic               divZero;
   logic [2*WIDTH-1:0] acc;

   logic               accept;
   logic               signedOp;
   logic               negA;
   logic               negB;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     trial;
   logic               divGeq;
   logic [WIDTH-1:0]   newRem;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   quotFix;
   logic [WIDTH-1:0]   remFix;

   assign accept   = bus.OpValid & ~bus.Stall & ~bus.Flush & (state == IDLE);
   assign signedOp = ~bus.Op[0];
   assign negA     = signedOp & bus.ReadData1[WIDTH-1];
   assign negB     = signedOp & bus.ReadData2[WIDTH-1];

   // Multiply: add multiplicand into the upper half, then shift {carry, acc} right.
   assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opB[0] ? opA : {WIDTH{1'b0}})};

   // Divide: remainder lives in acc upper half, quotient in the lower half.
   // When the trial value is >= divisor the true difference is < divisor, so a WIDTH-bit subtract is exact.
   assign trial  = {acc[2*WIDTH-1:WIDTH], opA[WIDTH-1]};
   assign divGeq = (trial >= {1'b0, opB});
   assign newRem = divGeq ? (trial[WIDTH-1:0] - opB) : trial[WIDTH-1:0];

   assign prodFix = (sa ^ sb) ? -acc : acc;
   assign quotFix = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign remFix  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         counter <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         opA     <= '0;
         opB     <= '0;
         rawA    <= '0;
         sa      <= 1'b0;
         sb      <= 1'b0;
         isDiv   <= 1'b0;
         divZero <= 1'b0;
         acc     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  case (bus.Op)
                     3'd2: hiReg <= bus.ReadData1;
                     3'd3: loReg <= bus.ReadData1;
                     3'd4, 3'd5, 3'd6, 3'd7: begin
                        opA     <= negA ? -bus.ReadData1 : bus.ReadData1;
                        opB     <= negB ? -bus.ReadData2 : bus.ReadData2;
                        rawA    <= bus.ReadData1;
                        sa      <= negA;
                        sb      <= negB;
                        isDiv   <= bus.Op[1];
                        divZero <= bus.Op[1] & (bus.ReadData2 == '0);
                        acc     <= '0;
                        counter <= '0;
                        state   <= RUN;
                     end
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (isDiv) begin
                  acc <= {newRem, acc[WIDTH-2:0], divGeq};
                  opA <= opA << 1;
               end else begin
                  acc <= {mulSum, acc[WIDTH-1:1]};
                  opB <= opB >> 1;
               end
               counter <= counter + CW'(1);
               if (counter == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (!isDiv) begin
                  hiReg <= prodFix[2*WIDTH-1:WIDTH];
                  loReg <= prodFix[WIDTH-1:0];
               end else if (divZero) begin
                  // Divide by zero: raw dividend to HI, all-ones quotient, no sign fix-up.
                  hiReg <= rawA;
                  loReg <= '1;
               end else begin
                  hiReg <= remFix;
                  loReg <= quotFix;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Busy     = (state != IDLE);
   assign bus.ALUStall = bus.OpValid & ~bus.Flush & bus.Busy;
   assign bus.Hi       = hiReg;
   assign bus.Lo       = loReg;

   always_comb begin
      bus.Result = '0;
      if (bus.OpValid && bus.Op == 3'd0) begin
         bus.Result = hiReg;
      end else if (bus.OpValid && bus.Op == 3'd1) begin
         bus.Result = loReg;
      end
   end
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed-vector bench for ex_muldiv_seq with hand-computed HI/LO results.
module tb_ex_muldiv_seq;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   vecCnt = 0;
   int   errCnt = 0;

   always #5 clk = ~clk;

   ex_muldiv_seq_if #(.WIDTH(W)) bus ();

   ex_muldiv_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vecCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.OpValid   = 1'b1;
      bus.Op        = op;
      bus.ReadData1 = a;
      bus.ReadData2 = b;
   endtask

   task automatic idle();
      bus.OpValid   = 1'b0;
      bus.Op        = 3'd0;
      bus.ReadData1 = '0;
      bus.ReadData2 = '0;
   endtask

   task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busyCyc);
      present(op, a, b);
      tick();
      idle();
      busyCyc = 0;
      while (bus.Busy && busyCyc < 100) begin
         busyCyc++;
         tick();
      end
   endtask

   task automatic checkOp(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] expHi, input logic [W-1:0] expLo);
      int n;
      runOp(op, a, b, n);
      checkVal({tag, " busy cycles"}, W'(n), 32'd33);
      checkVal({tag, " hi"}, bus.Hi, expHi);
      checkVal({tag, " lo"}, bus.Lo, expLo);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stallCyc;
      int guard;

      idle();
      bus.Stall = 1'b0;
      bus.Flush = 1'b0;
      rst_n     = 1'b0;
      #2;
      present(3'd0, '0, '0);
      #1;
      checkVal("reset busy", W'(bus.Busy), 32'd0);
      checkVal("reset hi", bus.Hi, 32'd0);
      checkVal("reset lo", bus.Lo, 32'd0);
      checkVal("reset alustall", W'(bus.ALUStall), 32'd0);
      checkVal("reset mfhi result", bus.Result, 32'd0);
      idle();
      tick();
      rst_n = 1'b1;
      tick();

      checkOp("multu max",   3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      checkOp("mult -3*7",   3'd4, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
      checkOp("div -7/2",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      checkOp("div ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      checkOp("divu by 0",   3'd7, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF);
      checkOp("div -5/0",    3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
      checkOp("multu 2^32",  3'd5, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
      checkOp("divu 100/7",  3'd7, 32'd100,      32'd7,        32'd2,        32'd14);
      checkOp("mult minneg", 3'd4, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

      // MTHI / MTLO write on the next edge only
      present(3'd2, 32'hCAFEF00D, '0);
      #1;
      checkVal("mthi before edge", bus.Hi, 32'h40000000);
      tick();
      checkVal("mthi after edge", bus.Hi, 32'hCAFEF00D);
      checkVal("mthi lo kept", bus.Lo, 32'h00000000);
      present(3'd3, 32'h000055AA, '0);
      tick();
      checkVal("mtlo after edge", bus.Lo, 32'h000055AA);
      present(3'd0, '0, '0);
      #1;
      checkVal("mfhi result", bus.Result, 32'hCAFEF00D);
      present(3'd1, '0, '0);
      #1;
      checkVal("mflo result", bus.Result, 32'h000055AA);

      // Stall blocks a would-be accept
      bus.Stall = 1'b1;
      present(3'd4, 32'd3, 32'd5);
      #1;
      checkVal("stall mult result", bus.Result, 32'd0);
      checkVal("stall mult alustall", W'(bus.ALUStall), 32'd0);
      tick();
      checkVal("stall no accept", W'(bus.Busy), 32'd0);
      bus.Stall = 1'b0;
      checkOp("mult -2*3", 3'd4, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);

      // Flush suppresses accept
      present(3'd6, 32'd100, 32'd3);
      bus.Flush = 1'b1;
      #1;
      checkVal("flush alustall", W'(bus.ALUStall), 32'd0);
      tick();
      bus.Flush = 1'b0;
      idle();
      checkVal("flush no busy", W'(bus.Busy), 32'd0);
      checkVal("flush hi kept", bus.Hi, 32'hFFFFFFFF);
      checkVal("flush lo kept", bus.Lo, 32'hFFFFFFFA);

      // MFLO during an in-flight MULTU
      present(3'd5, 32'd6, 32'd7);
      tick();
      idle();
      repeat (3) tick();
      present(3'd1, '0, '0);
      bus.Flush = 1'b1;
      #1;
      checkVal("busy flush alustall", W'(bus.ALUStall), 32'd0);
      bus.Flush = 1'b0;
      #1;
      checkVal("busy mflo alustall", W'(bus.ALUStall), 32'd1);
      tick();
      stallCyc = 0;
      guard    = 0;
      while (bus.Busy && guard < 100) begin
         if (bus.ALUStall) stallCyc++;
         guard++;
         tick();
      end
      checkVal("mflo stall cycles", W'(stallCyc), 32'd29);
      checkVal("mflo released", W'(bus.ALUStall), 32'd0);
      checkVal("mflo new lo", bus.Result, 32'd42);
      idle();
      tick();

      // Asynchronous reset in the middle of a divide
      present(3'd6, 32'd1000, 32'd7);
      tick();
      idle();
      repeat (9) tick();
      checkVal("div in flight", W'(bus.Busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkVal("midreset busy", W'(bus.Busy), 32'd0);
      checkVal("midreset hi", bus.Hi, 32'd0);
      checkVal("midreset lo", bus.Lo, 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      checkOp("mult -4*-5", 3'd4, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'd0, 32'd20);

      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
      $finish;
   end
endmodule
